// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the 5-stage (F/D/E/M/W) pipelined ARM core. It sits next to
// the controller and datapath and drives every stall, flush and forward select.
//   - Per-slot operand forwarding into E from M (ALUOutM) or W (ResultW).
//   - Load-use stall between a load in E and a consumer in D.
//   - PC-write-pending fetch stall and D flush.
//   - Variable-latency data-memory wait FSM (MemReqM/MemReadyM) with a
//     saturating wait counter and a sticky timeout flag.
//
// Parameters
//   REGW        register index width (index 15 is the PC)
//   NSRC        source operand slots per instruction
//   MEM_TIMEOUT wait cycles after which MemErr is raised (1..255)
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-low reset
//   SrcRegD/SrcValidD       D-stage source indices and per-slot read enables
//   SrcRegE/SrcValidE       E-stage source indices and per-slot read enables
//   WA3E/M/W, RegWriteE/M/W destination index and write enable per stage
//   MemtoRegE               E-stage instruction is a load
//   PCSrcD/E/M/W            stage's instruction writes the PC
//   BranchTakenE            branch resolved taken in E
//   MemReqM, MemReadyM      data-memory request / completion in M
//   ForwardE                2 bits per slot: 00 regfile, 10 ALUOutM, 01 ResultW
//   StallF/D/E/M            hold the pipeline register feeding that stage
//   FlushD/E/W              load a bubble into that stage
//   MemWaitCnt              cycles spent in the current wait (saturates at 255)
//   MemErr                  sticky memory timeout flag
//
// Optional build macro HAZ_PERF_EN adds 32-bit wrapping performance counters
// LdStallCnt, MemStallCnt and FlushCnt.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REGW        = 4,
  parameter int NSRC        = 3,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*REGW-1:0] SrcRegD,
  input  logic [NSRC-1:0]      SrcValidD,
  input  logic [NSRC*REGW-1:0] SrcRegE,
  input  logic [NSRC-1:0]      SrcValidE,
  input  logic [REGW-1:0]      WA3E,
  input  logic [REGW-1:0]      WA3M,
  input  logic [REGW-1:0]      WA3W,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemtoRegE,
  input  logic                 PCSrcD,
  input  logic                 PCSrcE,
  input  logic                 PCSrcM,
  input  logic                 PCSrcW,
  input  logic                 BranchTakenE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic [2*NSRC-1:0]    ForwardE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [7:0]           MemWaitCnt,
  output logic                 MemErr
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]          LdStallCnt,
  output logic [31:0]          MemStallCnt,
  output logic [31:0]          FlushCnt
`endif
);

  localparam logic [REGW-1:0] PC_IDX  = REGW'(15);
  localparam logic [7:0]      TO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state_q, state_d;
  logic   mem_wait;
  logic   ld_stall;
  logic   pc_wr_pend;
  logic   timeout_hit;
  logic   mem_err_q;

  // -------------------------------------------------------------------------
  // Forwarding into E. M is checked first so the youngest producer wins.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    ForwardE = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (SrcValidE[i] && RegWriteM && (WA3M != PC_IDX) &&
          (WA3M == SrcRegE[i*REGW +: REGW])) begin
        ForwardE[2*i +: 2] = 2'b10;
      end else if (SrcValidE[i] && RegWriteW && (WA3W != PC_IDX) &&
                   (WA3W == SrcRegE[i*REGW +: REGW])) begin
        ForwardE[2*i +: 2] = 2'b01;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Load-use detection: a load in E whose target is read by any valid D slot.
  // -------------------------------------------------------------------------
  always_comb begin
    ld_stall = 1'b0;
    if (MemtoRegE && RegWriteE && (WA3E != PC_IDX)) begin
      for (int i = 0; i < NSRC; i++) begin
        if (SrcValidD[i] && (SrcRegD[i*REGW +: REGW] == WA3E)) begin
          ld_stall = 1'b1;
        end
      end
    end
  end

  assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;

  // -------------------------------------------------------------------------
  // Memory-wait FSM. mem_wait is decoded combinationally from the current
  // state and the handshake so a miss stalls in the very cycle it appears.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    mem_wait = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          state_d  = S_WAIT;
          mem_wait = 1'b1;
        end
      end
      S_WAIT: begin
        if (MemReadyM) state_d = S_IDLE;
        else           mem_wait = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset wins over a pending miss so no stall is requested during reset.
    if (!reset) begin
      state_d  = S_IDLE;
      mem_wait = 1'b0;
    end
  end

  assign timeout_hit = mem_wait && (MemWaitCnt == TO_LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q    <= S_IDLE;
      MemWaitCnt <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // mem_wait=0 means either an idle cycle (count already 0) or the cycle
      // the FSM returns to IDLE, so clearing here covers both.
      if (!mem_wait)                MemWaitCnt <= '0;
      else if (MemWaitCnt != 8'hFF) MemWaitCnt <= MemWaitCnt + 8'd1;
      if (timeout_hit) mem_err_q <= 1'b1;
    end
  end

  // The flag is visible in the same cycle the count reaches the limit and
  // then held by the register until reset.
  assign MemErr = reset & (mem_err_q | timeout_hit);

  // -------------------------------------------------------------------------
  // Stall / flush outputs. A memory wait freezes E and D instead of flushing
  // them, so a taken branch or load-use bubble is deferred until it ends.
  // -------------------------------------------------------------------------
  assign StallM = mem_wait;
  assign StallE = mem_wait;
  assign StallD = reset & (mem_wait | ld_stall);
  assign StallF = reset & (mem_wait | ld_stall | pc_wr_pend);
  assign FlushW = ~reset | mem_wait;
  assign FlushE = ~reset | (~mem_wait & (ld_stall | BranchTakenE));
  assign FlushD = ~reset | (~mem_wait & (pc_wr_pend | PCSrcW | BranchTakenE));

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      LdStallCnt  <= '0;
      MemStallCnt <= '0;
      FlushCnt    <= '0;
    end else begin
      if (ld_stall && !mem_wait) LdStallCnt  <= LdStallCnt + 32'd1;
      if (mem_wait)              MemStallCnt <= MemStallCnt + 32'd1;
      if (FlushD || FlushE)      FlushCnt    <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule
